// File: rtl/tw4_run_ctrl.sv
// TW4 run/step/load sequencer: program memory, loader, cpu_en/cpu_rst strobes.
// Optional breakpoint logic is enabled with `define TW4_BREAKPOINT_EN.
module tw4_run_ctrl #(
  parameter int DIV = 4
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       cmd_valid,
  input  logic [1:0] cmd,
  output logic       cmd_ready,
  input  logic       ld_valid,
  input  logic [7:0] ld_data,
  output logic       ld_ready,
  input  logic [3:0] fetch_addr,
  output logic [7:0] fetch_data,
  output logic       cpu_en,
  output logic       cpu_rst,
  output logic       halted
`ifdef TW4_BREAKPOINT_EN
  ,
  input  logic       bp_valid,
  input  logic [3:0] bp_addr,
  output logic       bp_hit
`endif
);

  localparam logic [1:0] CMD_HALT = 2'd0;
  localparam logic [1:0] CMD_RUN  = 2'd1;
  localparam logic [1:0] CMD_STEP = 2'd2;
  localparam logic [1:0] CMD_LOAD = 2'd3;
  localparam logic [3:0] LAST     = 4'(DIV - 1);

  typedef enum logic [2:0] {
    S_CPURST,
    S_HALT,
    S_RUN,
    S_STEP,
    S_LOAD
  } state_t;

  state_t     state;
  logic [3:0] pre;
  logic [3:0] ptr;
  logic [7:0] mem [16];

  logic tick;
  logic bp;
  logic cmd_acc;
  logic ld_acc;

  assign tick = (state == S_RUN) && (pre == LAST);

`ifdef TW4_BREAKPOINT_EN
  assign bp     = tick && bp_valid && (fetch_addr == bp_addr);
  assign bp_hit = reset && bp;
`else
  assign bp = 1'b0;
`endif

  assign cmd_acc = cmd_valid && cmd_ready;
  assign ld_acc  = ld_valid && ld_ready;

  // Outputs are held low while reset is asserted, then decode state.
  always_comb begin
    cmd_ready = 1'b0;
    ld_ready  = 1'b0;
    cpu_en    = 1'b0;
    cpu_rst   = 1'b0;
    halted    = 1'b0;
    if (reset) begin
      unique case (state)
        S_CPURST: begin
          cpu_en  = 1'b1;
          cpu_rst = 1'b1;
        end
        S_HALT: begin
          halted    = 1'b1;
          cmd_ready = 1'b1;
        end
        S_RUN: begin
          cmd_ready = 1'b1;
          cpu_en    = tick && !bp;
        end
        S_STEP: cpu_en = 1'b1;
        S_LOAD: ld_ready = 1'b1;
        default: ;
      endcase
    end
  end

  assign fetch_data = (state == S_LOAD) ? 8'h00 : mem[fetch_addr];

  always_ff @(posedge clock) begin
    if (!reset) begin
      state <= S_CPURST;
      pre   <= 4'd0;
      ptr   <= 4'd0;
    end else begin
      unique case (state)
        S_CPURST: state <= S_HALT;
        S_HALT: begin
          if (cmd_acc) begin
            case (cmd)
              CMD_RUN: begin
                state <= S_RUN;
                pre   <= 4'd0;
              end
              CMD_STEP: state <= S_STEP;
              CMD_LOAD: begin
                state <= S_LOAD;
                ptr   <= 4'd0;
              end
              CMD_HALT: ;
            endcase
          end
        end
        S_RUN: begin
          if (bp) begin
            state <= S_HALT;
            pre   <= 4'd0;
          end else if (cmd_acc && cmd == CMD_HALT) begin
            state <= S_HALT;
            pre   <= 4'd0;
          end else if (cmd_acc && cmd == CMD_LOAD) begin
            state <= S_LOAD;
            ptr   <= 4'd0;
            pre   <= 4'd0;
          end else begin
            pre <= tick ? 4'd0 : pre + 4'd1;
          end
        end
        S_STEP: state <= S_HALT;
        S_LOAD: begin
          if (ld_acc) begin
            ptr <= ptr + 4'd1;
            if (ptr == 4'd15)
              state <= S_CPURST;
          end
        end
        default: state <= S_CPURST;
      endcase
    end
  end

  // Memory is deliberately not reset so a reset keeps the loaded program.
  always_ff @(posedge clock) begin
    if (ld_acc)
      mem[ptr] <= ld_data;
  end

endmodule

// File: tb/tb_tw4_run_ctrl.sv
// Directed bench for tw4_run_ctrl with DIV=4.
// Breakpoint checks are compiled in when TW4_BREAKPOINT_EN is defined.
module tb_tw4_run_ctrl;

  logic       clock = 1'b0;
  logic       reset;
  logic       cmd_valid;
  logic [1:0] cmd;
  logic       cmd_ready;
  logic       ld_valid;
  logic [7:0] ld_data;
  logic       ld_ready;
  logic [3:0] fetch_addr;
  logic [7:0] fetch_data;
  logic       cpu_en;
  logic       cpu_rst;
  logic       halted;
`ifdef TW4_BREAKPOINT_EN
  logic       bp_valid;
  logic [3:0] bp_addr;
  logic       bp_hit;
`endif

  int nchk = 0;
  int nerr = 0;

  tw4_run_ctrl #(.DIV(4)) dut (
    .clock      (clock),
    .reset      (reset),
    .cmd_valid  (cmd_valid),
    .cmd        (cmd),
    .cmd_ready  (cmd_ready),
    .ld_valid   (ld_valid),
    .ld_data    (ld_data),
    .ld_ready   (ld_ready),
    .fetch_addr (fetch_addr),
    .fetch_data (fetch_data),
    .cpu_en     (cpu_en),
    .cpu_rst    (cpu_rst),
    .halted     (halted)
`ifdef TW4_BREAKPOINT_EN
    ,
    .bp_valid   (bp_valid),
    .bp_addr    (bp_addr),
    .bp_hit     (bp_hit)
`endif
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    nchk++;
    if (obs !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic send_cmd(input logic [1:0] c);
    cmd       = c;
    cmd_valid = 1'b1;
    #1;
    chk("cmd_ready", cmd_ready, 1);
    cyc();
    cmd_valid = 1'b0;
    #1;
  endtask

  task automatic load_bytes(input int n, input logic [7:0] base);
    ld_valid = 1'b1;
    for (int i = 0; i < n; i++) begin
      ld_data = base + 8'(i);
      #1;
      chk("ld_ready", ld_ready, 1);
      chk("ld_cmd_ready", cmd_ready, 0);
      chk("ld_fetch0", fetch_data, 8'h00);
      cyc();
    end
    ld_valid = 1'b0;
    #1;
  endtask

  initial begin
    reset      = 1'b0;
    cmd_valid  = 1'b0;
    cmd        = 2'd0;
    ld_valid   = 1'b0;
    ld_data    = 8'h00;
    fetch_addr = 4'd0;
`ifdef TW4_BREAKPOINT_EN
    bp_valid   = 1'b0;
    bp_addr    = 4'd0;
`endif
    cyc();
    cyc();
    chk("rst_cpu_en", cpu_en, 0);
    chk("rst_cpu_rst", cpu_rst, 0);
    chk("rst_cmd_ready", cmd_ready, 0);
    chk("rst_ld_ready", ld_ready, 0);
    chk("rst_halted", halted, 0);
`ifdef TW4_BREAKPOINT_EN
    chk("rst_bp_hit", bp_hit, 0);
`endif
    reset = 1'b1;
    #1;
    chk("cpurst_en", cpu_en, 1);
    chk("cpurst_rst", cpu_rst, 1);
    cyc();
    chk("halt_halted", halted, 1);
    chk("halt_cpu_en", cpu_en, 0);

    // Full program load, then automatic CPU reset.
    send_cmd(2'd3);
    load_bytes(16, 8'h00);
    chk("load_end_en", cpu_en, 1);
    chk("load_end_rst", cpu_rst, 1);
    chk("load_end_ldr", ld_ready, 0);
    cyc();
    chk("load_halted", halted, 1);
    fetch_addr = 4'd5;
    #1;
    chk("fetch5", fetch_data, 8'h05);
    fetch_addr = 4'd15;
    #1;
    chk("fetch15", fetch_data, 8'h0F);

    // RUN: pulses at 4, 8, 12 cycles after accept.
    send_cmd(2'd1);
    for (int k = 1; k <= 12; k++) begin
      chk("run_en", cpu_en, (k % 4 == 0) ? 1 : 0);
      chk("run_rst", cpu_rst, 0);
      chk("run_halted", halted, 0);
      cyc();
    end
    send_cmd(2'd0);
    chk("run_halt", halted, 1);
    chk("run_halt_en", cpu_en, 0);

    // Two single steps.
    for (int s = 0; s < 2; s++) begin
      send_cmd(2'd2);
      chk("step_en", cpu_en, 1);
      chk("step_ready", cmd_ready, 0);
      chk("step_halted", halted, 0);
      cyc();
      chk("step_done", halted, 1);
      chk("step_off", cpu_en, 0);
    end

    // HALT when prescaler is 2, then RUN restarts a full period.
    send_cmd(2'd1);
    chk("pre0", cpu_en, 0);
    cyc();
    chk("pre1", cpu_en, 0);
    cyc();
    chk("pre2", cpu_en, 0);
    send_cmd(2'd0);
    for (int k = 0; k < 6; k++) begin
      chk("halt_quiet", cpu_en, 0);
      cyc();
    end
    send_cmd(2'd1);
    for (int k = 1; k <= 4; k++) begin
      chk("rerun_en", cpu_en, (k == 4) ? 1 : 0);
      cyc();
    end
    send_cmd(2'd0);

    // Reset in the middle of a load keeps written bytes.
    send_cmd(2'd3);
    load_bytes(7, 8'hA0);
    reset = 1'b0;
    cyc();
    chk("midrst_en", cpu_en, 0);
    reset = 1'b1;
    #1;
    chk("midrst_cpurst", cpu_rst, 1);
    chk("midrst_cpuen", cpu_en, 1);
    cyc();
    chk("midrst_halt", halted, 1);
    for (int a = 0; a < 8; a++) begin
      fetch_addr = 4'(a);
      #1;
      chk("retain", fetch_data, (a < 7) ? 32'hA0 + a : 32'h07);
    end
    send_cmd(2'd3);
    load_bytes(16, 8'h50);
    cyc();
    fetch_addr = 4'd0;
    #1;
    chk("reload0", fetch_data, 8'h50);
    fetch_addr = 4'd9;
    #1;
    chk("reload9", fetch_data, 8'h59);

`ifdef TW4_BREAKPOINT_EN
    begin
      logic [3:0] pc;
      logic       exp_en;
      logic       exp_hit;
      pc         = 4'd0;
      fetch_addr = pc;
      bp_addr    = 4'd3;
      bp_valid   = 1'b1;
      send_cmd(2'd1);
      for (int k = 1; k <= 16; k++) begin
        fetch_addr = pc;
        #1;
        exp_hit = (k % 4 == 0) && (pc == 4'd3);
        exp_en  = (k % 4 == 0) && (pc != 4'd3);
        chk("bp_en", cpu_en, exp_en);
        chk("bp_hit", bp_hit, exp_hit);
        cyc();
        if (exp_en)
          pc = pc + 4'd1;
      end
      chk("bp_halted", halted, 1);
      chk("bp_hit_clr", bp_hit, 0);
      chk("bp_pc", pc, 3);
      send_cmd(2'd2);
      chk("bp_step_en", cpu_en, 1);
      chk("bp_step_hit", bp_hit, 0);
      cyc();
      chk("bp_step_halt", halted, 1);
    end
`endif

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
